la_ioseq: RTL and testbench
===========================

LA_IOSEQ -- requirements
Module: la_ioseq

Purpose: IO-ring power-up/power-down sequencer. It drives the enable and hold controls consumed by the pad ring (corner, power and IO cells) on the ioring bus.

Interface
REQ-001 SHALL have parameter RINGW, default 8: width of the ioring control bus driven by this block.
REQ-002 SHALL have parameter DLY, default 16: cycles spent in each timed step; legal range 1..2^CNTW.
REQ-003 SHALL have parameter CNTW, default 8: step counter width.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port nreset, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port pgood, input, 1: asynchronous IO-supply power-good from the detector.
REQ-007 SHALL have port req_off, input, 1: synchronous power-down request, level sensitive.
REQ-008 SHALL have port enable_h, output, 1: pad high-voltage enable.
REQ-009 SHALL have port enable_vdda_h, output, 1: pad analog-domain enable.
REQ-010 SHALL have port hold_n, output, 1: pad hold release, active-low hold.
REQ-011 SHALL have port ready, output, 1: ring fully powered and released.
REQ-012 SHALL have port fault, output, 1: sticky flag for power-good lost while ON.
REQ-013 SHALL have port state, output, 3: current FSM state code.
REQ-014 SHALL have port ioring, output, RINGW: bit0=enable_h, bit1=enable_vdda_h, bit2=hold_n, bit3=ready; remaining bits 0.

Function
REQ-015 SHALL synchronize pgood through a 2-flop synchronizer (pgood_s); pgood_s is the only pgood seen by the FSM.
REQ-016 SHALL implement states OFF=0, DEB=1, EN=2, VDDA=3, REL=4, ON=5, DOWN=6; code 7 is illegal and SHALL go to OFF next cycle.
REQ-017 SHALL clear the step counter on every state entry; a timed state exits on the cycle its counter equals DLY-1, giving exactly DLY cycles of residency.
REQ-018 OFF -> DEB when pgood_s=1 and req_off=0; otherwise SHALL stay in OFF.
REQ-019 DEB counts consecutive pgood_s=1 cycles; if pgood_s=0 it SHALL go to OFF; after DLY cycles it SHALL go to EN.
REQ-020 EN -> VDDA, VDDA -> REL and REL -> ON, each after DLY cycles.
REQ-021 In EN, VDDA or REL, pgood_s=0 or req_off=1 SHALL go to DOWN on the next cycle, overriding the timed exit.
REQ-022 ON -> DOWN when req_off=1 or pgood_s=0; if pgood_s=0, fault SHALL set in the same cycle.
REQ-023 DOWN is non-interruptible and SHALL go to OFF after DLY cycles.
REQ-024 Outputs SHALL be registered Moore outputs:
- enable_h=1 in EN, VDDA, REL, ON, DOWN.
- enable_vdda_h=1 in VDDA, REL, ON, and in DOWN when entered from VDDA, REL or ON.
- hold_n=1 only in REL and ON.
- ready=1 only in ON.
REQ-025 hold_n SHALL fall on DOWN entry, before either enable falls; both enables SHALL fall together on DOWN -> OFF.
REQ-026 Simultaneous req_off=1 and pgood_s=0 in ON SHALL go to DOWN with fault set.
REQ-027 fault SHALL hold until reset; it does not block re-sequencing.
REQ-028 After DOWN -> OFF with req_off=1, the FSM SHALL remain in OFF until req_off=0.

Reset
REQ-029 While nreset=0 at a clk edge:
- state=OFF, counter=0, synchronizer flops=0.
- enable_h=0, enable_vdda_h=0, hold_n=0, ready=0, fault=0, ioring=0.
REQ-030 Reset mid-sequence, including in ON, SHALL force the REQ-029 values on that edge with no power-down sequence.

Verification (DLY=4)
REQ-031 pgood=1 steady after reset: enter DEB 3 cycles after reset release; enable_h rises 4 cycles after DEB entry, enable_vdda_h 4 cycles later, hold_n 4 cycles later, ready 4 cycles later.
REQ-032 pgood pulse of 3 cycles during DEB: return to OFF with all outputs 0; a following steady pgood restarts the full 4-cycle debounce.
REQ-033 req_off=1 in ON: next cycle hold_n=0, ready=0, state=6; 4 cycles later enables=0, state=0; fault stays 0.
REQ-034 pgood drops in ON: DOWN entered 2-3 cycles later with fault=1; fault stays 1 through a full re-power-up until nreset=0.
REQ-035 req_off=1 in VDDA: next cycle state=6 with enable_vdda_h=1 and hold_n=0; OFF after 4 cycles and held there while req_off=1.
REQ-036 nreset=0 for one cycle in ON: all outputs 0 on that edge; the sequence restarts from OFF.

Source files
------------

// File: rtl/la_ioseq.sv
// rtl/la_ioseq.sv - IO-ring power-up/power-down sequencer
module la_ioseq #(
  parameter int RINGW = 8,
  parameter int DLY   = 16,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             pgood,
  input  logic             req_off,
  output logic             enable_h,
  output logic             enable_vdda_h,
  output logic             hold_n,
  output logic             ready,
  output logic             fault,
  output logic [2:0]       state,
  output logic [RINGW-1:0] ioring
);

  typedef enum logic [2:0] {
    S_OFF  = 3'd0,
    S_DEB  = 3'd1,
    S_EN   = 3'd2,
    S_VDDA = 3'd3,
    S_REL  = 3'd4,
    S_ON   = 3'd5,
    S_DOWN = 3'd6
  } state_t;

  state_t          cur;
  state_t          nxt;
  logic [CNTW-1:0] cnt;
  logic            pgood_m;
  logic            pgood_s;
  logic            done;
  logic            fault_set;
  logic            vdda_nxt;

  // Two-flop synchronizer for the asynchronous power-good input
  always_ff @(posedge clk) begin
    if (!nreset) begin
      pgood_m <= 1'b0;
      pgood_s <= 1'b0;
    end else begin
      pgood_m <= pgood;
      pgood_s <= pgood_m;
    end
  end

  // Next-state decode; abort paths take priority over timed exits
  always_comb begin
    nxt       = cur;
    fault_set = 1'b0;
    done      = (cnt == CNTW'(DLY - 1));
    case (cur)
      S_OFF:  if (pgood_s && !req_off) nxt = S_DEB;
      S_DEB: begin
        if (!pgood_s)  nxt = S_OFF;
        else if (done) nxt = S_EN;
      end
      S_EN: begin
        if (!pgood_s || req_off) nxt = S_DOWN;
        else if (done)           nxt = S_VDDA;
      end
      S_VDDA: begin
        if (!pgood_s || req_off) nxt = S_DOWN;
        else if (done)           nxt = S_REL;
      end
      S_REL: begin
        if (!pgood_s || req_off) nxt = S_DOWN;
        else if (done)           nxt = S_ON;
      end
      S_ON: begin
        if (!pgood_s || req_off) nxt = S_DOWN;
        fault_set = !pgood_s;
      end
      S_DOWN: if (done) nxt = S_OFF;
      default: nxt = S_OFF;
    endcase
  end

  // Analog enable stays up through DOWN only if it was already up on entry
  always_comb begin
    vdda_nxt = 1'b0;
    case (nxt)
      S_VDDA, S_REL, S_ON: vdda_nxt = 1'b1;
      S_DOWN: vdda_nxt = (cur == S_DOWN) ? enable_vdda_h
                                         : (cur inside {S_VDDA, S_REL, S_ON});
      default: vdda_nxt = 1'b0;
    endcase
  end

  // State, step counter and Moore outputs registered from the next state
  always_ff @(posedge clk) begin
    if (!nreset) begin
      cur           <= S_OFF;
      cnt           <= '0;
      enable_h      <= 1'b0;
      enable_vdda_h <= 1'b0;
      hold_n        <= 1'b0;
      ready         <= 1'b0;
      fault         <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt != cur || cur == S_OFF || cur == S_ON) cnt <= '0;
      else                                           cnt <= cnt + 1'b1;
      enable_h      <= (nxt inside {S_EN, S_VDDA, S_REL, S_ON, S_DOWN});
      enable_vdda_h <= vdda_nxt;
      hold_n        <= (nxt inside {S_REL, S_ON});
      ready         <= (nxt == S_ON);
      if (fault_set) fault <= 1'b1;
    end
  end

  // Pad-ring control bus mirrors the registered controls
  always_comb begin
    ioring    = '0;
    ioring[0] = enable_h;
    ioring[1] = enable_vdda_h;
    ioring[2] = hold_n;
    ioring[3] = ready;
  end

  assign state = cur;

endmodule

// File: tb/tb_la_ioseq.sv
// tb/tb_la_ioseq.sv - self-checking bench for la_ioseq
module tb_la_ioseq;
  localparam int RINGW = 8;
  localparam int DLY   = 4;
  localparam int CNTW  = 8;

  logic             clk = 1'b0;
  logic             nreset = 1'b0;
  logic             pgood = 1'b0;
  logic             req_off = 1'b0;
  logic             enable_h;
  logic             enable_vdda_h;
  logic             hold_n;
  logic             ready;
  logic             fault;
  logic [2:0]       state;
  logic [RINGW-1:0] ioring;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  la_ioseq #(.RINGW(RINGW), .DLY(DLY), .CNTW(CNTW)) dut (
    .clk(clk), .nreset(nreset), .pgood(pgood), .req_off(req_off),
    .enable_h(enable_h), .enable_vdda_h(enable_vdda_h), .hold_n(hold_n),
    .ready(ready), .fault(fault), .state(state), .ioring(ioring)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase number, cycles resident, sticky fault
  int m_p1, m_p2, m_st, m_age, m_fault, m_vd;
  initial begin
    m_p1 = 0; m_p2 = 0; m_st = 0; m_age = 0; m_fault = 0; m_vd = 0;
  end

  always @(posedge clk) begin
    int pg, nx;
    if (!nreset) begin
      m_p1 = 0; m_p2 = 0; m_st = 0; m_age = 0; m_fault = 0; m_vd = 0;
    end else begin
      pg = m_p2;
      m_p2 = m_p1;
      m_p1 = int'(pgood);
      nx = m_st;
      m_age = m_age + 1;
      case (m_st)
        0: if (pg == 1 && !req_off) nx = 1;
        1: if (pg == 0) nx = 0; else if (m_age == DLY) nx = 2;
        2, 3, 4: if (pg == 0 || req_off) nx = 6; else if (m_age == DLY) nx = m_st + 1;
        5: if (pg == 0 || req_off) begin nx = 6; if (pg == 0) m_fault = 1; end
        6: if (m_age == DLY) nx = 0;
        default: nx = 0;
      endcase
      if (nx != m_st) begin
        if (nx == 6) m_vd = (m_st == 3 || m_st == 4 || m_st == 5) ? 1 : 0;
        m_age = 0;
        m_st = nx;
      end
    end
  end

  function automatic logic [15:0] model_vec();
    logic en, vd, hn, rd;
    en = (m_st >= 2 && m_st <= 6);
    vd = (m_st >= 3 && m_st <= 5) || (m_st == 6 && m_vd == 1);
    hn = (m_st == 4 || m_st == 5);
    rd = (m_st == 5);
    return {3'(m_st), m_fault[0], rd, hn, vd, en, 4'b0000, rd, hn, vd, en};
  endfunction

  // Every-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    logic [15:0] act, exp_v;
    if (cmp_en) begin
      act   = {state, fault, ready, hold_n, enable_vdda_h, enable_h, ioring};
      exp_v = model_vec();
      checks = checks + 1;
      if (act !== exp_v) begin
        failures = failures + 1;
        $display("FAIL model_cmp t=%0t actual=%h expected=%h", $time, act, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks = checks + 1;
    if (act !== exp_v) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h expected=%h", name, act, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    step(3);
    cmp_en = 1'b1;
    chk("reset_state", {29'd0, state}, 0);
    chk("reset_ioring", {24'd0, ioring}, 0);
    chk("reset_fault", {31'd0, fault}, 0);

    // Power-up with pgood steady
    pgood = 1'b1; nreset = 1'b1;
    step(2); chk("pre_deb_state", {29'd0, state}, 0);
    step(1); chk("deb_entry", {29'd0, state}, 1);
    chk("model_deb_entry", m_st, 1);
    step(3); chk("en_not_yet", {31'd0, enable_h}, 0);
    step(1); chk("enable_h_rise", {31'd0, enable_h}, 1);
    step(4); chk("vdda_rise", {31'd0, enable_vdda_h}, 1);
    chk("hold_still_low", {31'd0, hold_n}, 0);
    step(4); chk("hold_rise", {31'd0, hold_n}, 1);
    step(4); chk("ready_rise", {31'd0, ready}, 1);
    chk("on_ioring", {24'd0, ioring}, 32'h0f);
    chk("model_on", m_st, 5);

    // Orderly power-down request in ON
    req_off = 1'b1;
    step(1);
    chk("down_state", {29'd0, state}, 6);
    chk("down_hold", {31'd0, hold_n}, 0);
    chk("down_ready", {31'd0, ready}, 0);
    chk("down_enables", {30'd0, enable_vdda_h, enable_h}, 3);
    step(3); chk("down_held", {29'd0, state}, 6);
    step(1);
    chk("down_to_off", {29'd0, state}, 0);
    chk("off_enables", {30'd0, enable_vdda_h, enable_h}, 0);
    chk("no_fault", {31'd0, fault}, 0);
    step(5); chk("off_while_req", {29'd0, state}, 0);
    req_off = 1'b0;
    step(1); chk("resequence_deb", {29'd0, state}, 1);
    step(16); chk("on_again", {29'd0, state}, 5);

    // Power-good lost in ON
    pgood = 1'b0;
    step(2); chk("on_before_sync", {29'd0, state}, 5);
    step(1);
    chk("pg_loss_down", {29'd0, state}, 6);
    chk("pg_loss_fault", {31'd0, fault}, 1);
    chk("model_fault", m_fault, 1);
    pgood = 1'b1;
    step(4); chk("pg_loss_off", {29'd0, state}, 0);
    step(1); chk("pg_loss_redeb", {29'd0, state}, 1);
    step(16);
    chk("fault_repower_on", {29'd0, state}, 5);
    chk("fault_sticky", {31'd0, fault}, 1);

    // One-cycle reset in ON
    nreset = 1'b0;
    step(1);
    chk("rst_on_ioring", {24'd0, ioring}, 0);
    chk("rst_on_fault", {31'd0, fault}, 0);
    chk("rst_on_state", {29'd0, state}, 0);
    nreset = 1'b1;
    step(3); chk("rst_restart_deb", {29'd0, state}, 1);

    // Power-down request in VDDA
    step(8); chk("at_vdda", {29'd0, state}, 3);
    req_off = 1'b1;
    step(1);
    chk("vdda_abort_state", {29'd0, state}, 6);
    chk("vdda_abort_vdda", {31'd0, enable_vdda_h}, 1);
    chk("vdda_abort_hold", {31'd0, hold_n}, 0);
    step(4); chk("vdda_abort_off", {29'd0, state}, 0);
    step(4); chk("vdda_abort_held", {29'd0, state}, 0);

    // Short pgood pulse during debounce
    nreset = 1'b0; pgood = 1'b0; req_off = 1'b0;
    step(2);
    nreset = 1'b1;
    step(1);
    pgood = 1'b1;
    step(3); chk("pulse_deb", {29'd0, state}, 1);
    pgood = 1'b0;
    step(3);
    chk("pulse_off", {29'd0, state}, 0);
    chk("pulse_ioring", {24'd0, ioring}, 0);
    pgood = 1'b1;
    step(3); chk("pulse_redeb", {29'd0, state}, 1);
    step(3); chk("pulse_full_deb", {31'd0, enable_h}, 0);
    step(1); chk("pulse_en", {29'd0, state}, 2);
    step(2);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
